// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the framed serial transmitter.
//   tx_state_t          : transmitter FSM states
//   SERIAL_IDLE_LEVEL   : line level while idle and during the stop bit
//   SERIAL_START_LEVEL  : line level of the start bit
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  localparam logic SERIAL_IDLE_LEVEL  = 1'b1;
  localparam logic SERIAL_START_LEVEL = 1'b0;

endpackage : serial_pkg

// File: rtl/flex_pts_sr.sv
// -----------------------------------------------------------------------------
// flex_pts_sr
// Parameterised parallel-to-serial shift register. Resets to all ones (the
// idle line level); load has priority over shift. Vacated positions are
// filled with the idle level.
// Parameters:
//   NUM_BITS     : register width (>= 2)
//   SHIFT_MSB    : 1 = MSB presented first, 0 = LSB presented first
// Ports:
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset
//   load_enable  : load parallel_in
//   shift_enable : advance to the next bit
//   parallel_in  : word to load
//   serial_out   : bit currently presented (combinational from the register)
// -----------------------------------------------------------------------------
module flex_pts_sr
  import serial_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] r_sr;
  logic [NUM_BITS-1:0] w_sr_next;

  always_comb begin
    // NOTE: default assignment first so every path drives w_sr_next; no latch.
    w_sr_next = r_sr;
    if (load_enable) begin
      w_sr_next = parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) begin
        w_sr_next = {r_sr[NUM_BITS-2:0], SERIAL_IDLE_LEVEL};
      end else begin
        w_sr_next = {SERIAL_IDLE_LEVEL, r_sr[NUM_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!n_rst) begin
      r_sr <= {NUM_BITS{SERIAL_IDLE_LEVEL}};
    end else begin
      r_sr <= w_sr_next;
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? r_sr[NUM_BITS-1] : r_sr[0];

endmodule : flex_pts_sr

// File: rtl/serial_tx_frame.sv
// -----------------------------------------------------------------------------
// serial_tx_frame
// Framed serial transmitter: start bit (0), DATA_BITS data bits, optional
// parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT cycles. Back-to-back
// frames are gap-free because a new word may be accepted in the final stop
// cycle.
// Optional feature macro: SERIAL_TX_PARITY_EN (parity bit, sense PARITY_ODD).
// Parameters:
//   DATA_BITS    : data bits per frame (>= 2)
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   SHIFT_MSB    : 1 = MSB first, 0 = LSB first
//   PARITY_ODD   : 0 = even, 1 = odd (parity builds only)
// Ports:
//   clk        : clock, rising edge
//   n_rst      : asynchronous active-low reset
//   tx_data    : word to send, sampled on acceptance
//   tx_valid   : tx_data valid
//   tx_ready   : word can be accepted this cycle (combinational)
//   serial_out : serial line, registered, idles high
//   tx_busy    : frame in progress
//   tx_done    : registered one-cycle pulse after the last stop cycle
// -----------------------------------------------------------------------------
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int SHIFT_MSB    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DATA_BITS - 1);

  // Elaboration-time parameter sanity checks.
  if (DATA_BITS < 2) begin : g_bad_data_bits
    $error("serial_tx_frame: DATA_BITS must be 2 or more");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("serial_tx_frame: CLKS_PER_BIT must be 2 or more");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("serial_tx_frame: PARITY_ODD must be 0 or 1");
  end

  tx_state_t     r_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_bit_cnt;
  logic          r_serial_out;
  logic          r_tx_done;
`ifdef SERIAL_TX_PARITY_EN
  logic          r_parity;
`endif

  logic w_bit_end;
  logic w_tx_ready;
  logic w_accept;
  logic w_shift;
  logic w_sr_out;

  assign w_bit_end  = (r_timer == TIMER_LAST);
  assign w_tx_ready = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
  assign w_accept   = tx_valid && w_tx_ready;

  // The output register samples the shift register's current bit at the
  // boundary into each data bit, and the shift register advances on that
  // same edge so the following bit is already presented at the next boundary.
  // Hence a shift at the start->data boundary and at every data->data
  // boundary, but none at the end of the last data bit.
  assign w_shift = w_bit_end &&
                   ((r_state == START) ||
                    ((r_state == DATA) && (r_bit_cnt != COUNT_LAST)));

  flex_pts_sr #(
    .NUM_BITS  (DATA_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_enable  (w_accept),
    .shift_enable (w_shift),
    .parallel_in  (tx_data),
    .serial_out   (w_sr_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_serial_out <= SERIAL_IDLE_LEVEL;
      r_tx_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_tx_done <= 1'b0;

      // Bit timer runs in every non-idle state and wraps at each bit boundary.
      if ((r_state == IDLE) || w_bit_end) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      case (r_state)
        IDLE: begin
          r_serial_out <= SERIAL_IDLE_LEVEL;
          if (w_accept) begin
            r_state      <= START;
            r_serial_out <= SERIAL_START_LEVEL;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_state      <= DATA;
            r_bit_cnt    <= '0;
            r_serial_out <= w_sr_out;
`ifdef SERIAL_TX_PARITY_EN
            r_parity     <= w_sr_out ^ PARITY_ODD[0];
`endif
          end
        end

        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == COUNT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              r_state      <= PARITY;
              r_serial_out <= r_parity;
`else
              r_state      <= STOP;
              r_serial_out <= SERIAL_IDLE_LEVEL;
`endif
            end else begin
              r_bit_cnt    <= r_bit_cnt + CW'(1);
              r_serial_out <= w_sr_out;
`ifdef SERIAL_TX_PARITY_EN
              r_parity     <= r_parity ^ w_sr_out;
`endif
            end
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state      <= STOP;
            r_serial_out <= SERIAL_IDLE_LEVEL;
          end
        end
`endif

        STOP: begin
          if (w_bit_end) begin
            r_tx_done <= 1'b1;
            if (w_accept) begin
              r_state      <= START;
              r_serial_out <= SERIAL_START_LEVEL;
            end else begin
              r_state      <= IDLE;
              r_serial_out <= SERIAL_IDLE_LEVEL;
            end
          end
        end

        default: begin
          r_state      <= IDLE;
          r_serial_out <= SERIAL_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign tx_ready   = w_tx_ready;
  assign serial_out = r_serial_out;
  assign tx_busy    = (r_state != IDLE);
  assign tx_done    = r_tx_done;

endmodule : serial_tx_frame
